pool_blk: RTL and testbench
===========================

Name: pool_blk

Overview:
Streaming pooling stage placed directly after conv_blk. It consumes the conv_blk result stream (o_en / o_conv_result, raster order) and emits pooled results, one per pooling window, ready for BRAM write-back. It generalises the fixed 2x2 max-pool of the first convolutional block to parametrised window size, data width, parallel channels and max/average mode.

Parameters:
DATA_WIDTH, 48, signed width of each channel sample
CHANNELS, 1, parallel lanes packed in i_data/o_data, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
FM_SIZE, 4, input map height and width (square)
POOL_SIZE, 2, window height/width; pooling stride equals POOL_SIZE (non-overlapping); power of 2, >=2
MODE, 0, 0 = max, 1 = average

Ports:
i_clk  in  1  clock; all logic rising-edge
i_rst  in  1  synchronous active-high reset
i_go  in  1  frame start; sampled in IDLE only
i_en  in  1  input sample valid (driven by conv_blk o_en)
i_data  in  DATA_WIDTH*CHANNELS  input samples, signed
o_en  out  1  one-cycle pulse, o_data valid
o_data  out  DATA_WIDTH*CHANNELS  pooled result, signed
o_busy  out  1  high in RUN
o_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: state IDLE; o_en=0, o_data=0, o_busy=0, o_done=0; row/column counters and accumulators cleared. Reset mid-frame aborts the frame; no o_en or o_done follows until a new i_go.
- FSM: IDLE -> RUN on i_go (counters cleared). RUN -> DONE in the cycle the FM_SIZE^2-th i_en sample is accepted. DONE -> IDLE unconditionally after 1 cycle; o_done=1 only in DONE.
- i_en is ignored in IDLE and DONE. i_go is ignored outside IDLE.
- Counters: col 0..FM_SIZE-1 and row 0..FM_SIZE-1 advance only on accepted i_en; col wraps to 0 and increments row. Gaps in i_en stall the block without changing results.
- Row buffer: OUT_W = FM_SIZE/POOL_SIZE (floor) accumulators per channel, indexed j = col/POOL_SIZE.
- Per accepted sample with row < OUT_W*POOL_SIZE and col < OUT_W*POOL_SIZE:
  - window-first sample (row%P==0 and col%P==0): acc[j] <= sample.
  - otherwise, max mode: acc[j] <= signed max(acc[j], sample); average mode: acc[j] <= acc[j] + sample.
- Samples in trailing rows/columns beyond OUT_W*POOL_SIZE are accepted, counted and discarded.
- Emission: when the window-last sample (row%P==P-1 and col%P==P-1) is accepted, o_en=1 in the next cycle. o_data is the combined window result, so latency is 1 cycle from the last window sample. Outputs appear in raster order of windows, OUT_W^2 per frame.
- o_data holds its last value when o_en=0.
- Average width: acc is DATA_WIDTH+2*log2(POOL_SIZE) bits, sign-extended. Result = acc >>> 2*log2(POOL_SIZE) (floor toward -inf), truncated to DATA_WIDTH. Overflow is impossible.
- The final o_en pulse (if the last sample closes a window) coincides with the DONE cycle, so o_done and o_en are both high in that cycle.
- Channels are fully independent; compare and add are per lane.

Optional Feature:
POOL_RELU_EN: when defined, each output lane is clamped to 0 if negative, after max/average and in the same cycle (latency unchanged). When undefined, signed results pass through unchanged.

Test Plan:
- FM_SIZE=4, P=2, MODE=0, i_go then samples 0..15 on consecutive i_en -> o_en pulses with o_data 5, 7, 13, 15; each pulse 1 cycle after samples 5, 7, 13, 15; o_done in the cycle of the final o_en; then IDLE.
- Same stimulus, MODE=1 -> 2, 4, 10, 12. Window {-1,-2,-3,-3} -> -3 (floor of -2.25).
- Signed max: window {-7, -3, -9, -5} -> -3. CHANNELS=2 with lane1 = lane0 negated -> lane1 shows the maximum of the negated values, independent of lane0.
- FM_SIZE=5, P=2, samples 0..24 with i_en low every other cycle -> 6, 8, 16, 18; row 4 and column 4 discarded; o_done one cycle after the 25th sample.
- Assert i_rst after 9 samples -> all outputs 0 next cycle, no further o_en. New i_go and a full frame -> correct 4 results.
- POOL_RELU_EN defined, all-negative frame -> four o_en pulses with o_data=0. Undefined -> negative maxima.

Source files
------------

// File: rtl/pool_blk.sv
// Streaming max/average pooling over a raster-order feature map, non-overlapping square windows.
// Define POOL_RELU_EN to clamp negative pooled lanes to zero.
module pool_blk #(
    parameter int DATA_WIDTH = 48,
    parameter int CHANNELS   = 1,
    parameter int FM_SIZE    = 4,
    parameter int POOL_SIZE  = 2,
    parameter int MODE       = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_go,
    input  logic                           i_en,
    input  logic [DATA_WIDTH*CHANNELS-1:0] i_data,
    output logic                           o_en,
    output logic [DATA_WIDTH*CHANNELS-1:0] o_data,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int LOG2P = $clog2(POOL_SIZE);
    localparam int SH    = 2 * LOG2P;
    localparam int ACC_W = DATA_WIDTH + SH;
    localparam int OUT_W = FM_SIZE / POOL_SIZE;
    localparam int LIM   = OUT_W * POOL_SIZE;
    localparam int CW    = (FM_SIZE > 1) ? $clog2(FM_SIZE) : 1;
    localparam int JW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(FM_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e                          state_q, state_d;
    logic [CW-1:0]                   col_q, col_d, row_q, row_d;
    logic signed [ACC_W-1:0]         acc_q [OUT_W][CHANNELS];
    logic signed [ACC_W-1:0]         acc_d [OUT_W][CHANNELS];
    logic                            o_en_q, o_en_d;
    logic [DATA_WIDTH*CHANNELS-1:0]  o_data_q, o_data_d;

    logic          accept, in_area, win_first, win_last;
    logic [JW-1:0] j;

    assign accept    = (state_q == S_RUN) && i_en;
    assign in_area   = (int'(row_q) < LIM) && (int'(col_q) < LIM);
    assign win_first = (row_q[LOG2P-1:0] == '0) && (col_q[LOG2P-1:0] == '0);
    assign win_last  = (&row_q[LOG2P-1:0]) && (&col_q[LOG2P-1:0]);
    assign j         = JW'(col_q >> LOG2P);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_go) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_RUN: begin
                if (i_en) begin
                    if (col_q == LAST) begin
                        col_d = '0;
                        if (row_q == LAST) begin
                            row_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Combined window value is formed from the incoming sample so the result leaves one cycle later.
    always_comb begin
        logic signed [ACC_W-1:0] smp;
        logic signed [ACC_W-1:0] nxt;
        logic signed [ACC_W-1:0] shf;
        logic [DATA_WIDTH-1:0]   res;
        smp      = '0;
        nxt      = '0;
        shf      = '0;
        res      = '0;
        acc_d    = acc_q;
        o_en_d   = 1'b0;
        o_data_d = o_data_q;
        if (accept && in_area) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                smp = {{SH{i_data[ch*DATA_WIDTH+DATA_WIDTH-1]}}, i_data[ch*DATA_WIDTH +: DATA_WIDTH]};
                if (win_first)
                    nxt = smp;
                else if (MODE == 1)
                    nxt = acc_q[j][ch] + smp;
                else
                    nxt = (smp > acc_q[j][ch]) ? smp : acc_q[j][ch];
                acc_d[j][ch] = nxt;
                shf = (MODE == 1) ? (nxt >>> SH) : nxt;
                res = shf[DATA_WIDTH-1:0];
`ifdef POOL_RELU_EN
                if (res[DATA_WIDTH-1])
                    res = '0;
`else
`endif
                if (win_last)
                    o_data_d[ch*DATA_WIDTH +: DATA_WIDTH] = res;
            end
            o_en_d = win_last;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            o_en_q   <= 1'b0;
            o_data_q <= '0;
            for (int w = 0; w < OUT_W; w++)
                for (int ch = 0; ch < CHANNELS; ch++)
                    acc_q[w][ch] <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            o_en_q   <= o_en_d;
            o_data_q <= o_data_d;
            acc_q    <= acc_d;
        end
    end

    assign o_en   = o_en_q;
    assign o_data = o_data_q;
    assign o_busy = (state_q == S_RUN);
    assign o_done = (state_q == S_DONE);

endmodule

// File: tb/tb_pool_blk.sv
// Directed bench for pool_blk: max (2 lanes), average, and 5x5 map instances share one stimulus bus.
module tb_pool_blk;
  localparam int DW = 48;
  localparam longint MAXP = 64'sd140737488355327;

  logic clk = 1'b0;
  logic rst, go, en;
  logic [2*DW-1:0] din;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic m_en, m_busy, m_done, a_en, a_busy, a_done, f_en, f_busy, f_done;
  logic [2*DW-1:0] m_data;
  logic [DW-1:0] a_data, f_data;

  pool_blk #(.DATA_WIDTH(DW), .CHANNELS(2), .FM_SIZE(4), .POOL_SIZE(2), .MODE(0)) u_max (
    .i_clk(clk), .i_rst(rst), .i_go(go), .i_en(en), .i_data(din),
    .o_en(m_en), .o_data(m_data), .o_busy(m_busy), .o_done(m_done));
  pool_blk #(.DATA_WIDTH(DW), .CHANNELS(1), .FM_SIZE(4), .POOL_SIZE(2), .MODE(1)) u_avg (
    .i_clk(clk), .i_rst(rst), .i_go(go), .i_en(en), .i_data(din[DW-1:0]),
    .o_en(a_en), .o_data(a_data), .o_busy(a_busy), .o_done(a_done));
  pool_blk #(.DATA_WIDTH(DW), .CHANNELS(1), .FM_SIZE(5), .POOL_SIZE(2), .MODE(0)) u_fm5 (
    .i_clk(clk), .i_rst(rst), .i_go(go), .i_en(en), .i_data(din[DW-1:0]),
    .o_en(f_en), .o_data(f_data), .o_busy(f_busy), .o_done(f_done));

  // scoreboard
  int sel = 0;
  logic cur_en, cur_done;
  logic [2*DW-1:0] cur_data;
  logic [2*DW-1:0] exp_q[$];
  int exp_cyc[$];
  logic [2*DW-1:0] got_q[$];
  int got_cyc[$];
  int done_cyc[$];
  logic [2*DW-1:0] stim[25];
  int acc_edge[25];
  int n_cmp = 0;
  int n_err = 0;

  always_comb begin
    cur_en = 1'b0;
    cur_done = 1'b0;
    cur_data = '0;
    case (sel)
      0: begin cur_en = m_en; cur_done = m_done; cur_data = m_data; end
      1: begin cur_en = a_en; cur_done = a_done; cur_data = {{DW{1'b0}}, a_data}; end
      default: begin cur_en = f_en; cur_done = f_done; cur_data = {{DW{1'b0}}, f_data}; end
    endcase
  end

  always @(negedge clk) begin
    if (cur_en) begin
      got_q.push_back(cur_data);
      got_cyc.push_back(cyc);
    end
    if (cur_done) done_cyc.push_back(cyc);
  end

  function automatic longint rl(input longint v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [2*DW-1:0] pk(input longint l0, input longint l1);
    logic [63:0] a, b;
    a = l0;
    b = l1;
    return {b[DW-1:0], a[DW-1:0]};
  endfunction

  function automatic logic [2*DW-1:0] p1(input longint v);
    logic [63:0] a;
    a = v;
    return {{DW{1'b0}}, a[DW-1:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [2*DW-1:0] obs, input logic [2*DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag);
    check_eq({tag, "_count"}, 96'(got_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_data%0d", tag, i), (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      if (i < exp_cyc.size())
        check_eq($sformatf("%s_cyc%0d", tag, i),
                 (i < got_cyc.size()) ? 96'(got_cyc[i]) : '1, 96'(exp_cyc[i]));
    end
    exp_q.delete();
    exp_cyc.delete();
  endtask

  task automatic check_done(input string tag, input int exp_c);
    check_eq({tag, "_done_n"}, 96'(done_cyc.size()), 96'(1));
    check_eq({tag, "_done_c"}, (done_cyc.size() > 0) ? 96'(done_cyc[0]) : '1, 96'(exp_c));
  endtask

  task automatic clear_caps();
    got_q.delete();
    got_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_caps();
  endtask

  task automatic start_frame();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic send(input int idx, input bit gap);
    if (gap) begin
      en = 1'b0;
      @(negedge clk);
    end
    en = 1'b1;
    din = stim[idx];
    acc_edge[idx] = cyc + 1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic drive_frame(input int n, input bit gaps);
    start_frame();
    for (int i = 0; i < n; i++) send(i, gaps);
    repeat (3) @(negedge clk);
  endtask

  task automatic push_fm4_cycles();
    exp_cyc.push_back(acc_edge[5]);
    exp_cyc.push_back(acc_edge[7]);
    exp_cyc.push_back(acc_edge[13]);
    exp_cyc.push_back(acc_edge[15]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; go = 1'b0; en = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_en", 96'(m_en), 96'(0));
    check_eq("rst_data", m_data, 96'(0));
    check_eq("rst_busy", 96'(m_busy), 96'(0));
    check_eq("rst_done", 96'(m_done), 96'(0));
    rst = 1'b0;

    // 4x4 ramp, max, lane1 negated
    for (int i = 0; i < 25; i++) stim[i] = pk(i, -i);
    sel = 0;
    do_reset();
    drive_frame(16, 1'b0);
    exp_q.push_back(pk(rl(5), rl(0)));
    exp_q.push_back(pk(rl(7), rl(-2)));
    exp_q.push_back(pk(rl(13), rl(-8)));
    exp_q.push_back(pk(rl(15), rl(-10)));
    push_fm4_cycles();
    check_stream("max_ramp");
    check_done("max_ramp", acc_edge[15]);
    check_eq("max_hold", m_data, pk(rl(15), rl(-10)));
    check_eq("max_idle", 96'(m_busy), 96'(0));

    // 4x4 ramp, average
    sel = 1;
    do_reset();
    drive_frame(16, 1'b0);
    exp_q.push_back(p1(rl(2)));
    exp_q.push_back(p1(rl(4)));
    exp_q.push_back(p1(rl(10)));
    exp_q.push_back(p1(rl(12)));
    push_fm4_cycles();
    check_stream("avg_ramp");
    check_done("avg_ramp", acc_edge[15]);

    // signed windows and full-scale values
    stim[0] = pk(-7, 7);     stim[1] = pk(-3, 3);     stim[4] = pk(-9, 9);     stim[5] = pk(-5, 5);
    stim[2] = pk(-1, 1);     stim[3] = pk(-2, 2);     stim[6] = pk(-3, 3);     stim[7] = pk(-3, 3);
    stim[8] = pk(100, -100); stim[9] = pk(-50, 50);   stim[12] = pk(7, -7);    stim[13] = pk(-200, 200);
    stim[10] = pk(MAXP, -MAXP); stim[11] = pk(MAXP, -MAXP);
    stim[14] = pk(MAXP, -MAXP); stim[15] = pk(MAXP, -MAXP);
    sel = 0;
    do_reset();
    drive_frame(16, 1'b0);
    exp_q.push_back(pk(rl(-3), rl(9)));
    exp_q.push_back(pk(rl(-1), rl(3)));
    exp_q.push_back(pk(rl(100), rl(200)));
    exp_q.push_back(pk(rl(MAXP), rl(-MAXP)));
    push_fm4_cycles();
    check_stream("max_signed");

    sel = 1;
    do_reset();
    drive_frame(16, 1'b0);
    exp_q.push_back(p1(rl(-6)));
    exp_q.push_back(p1(rl(-3)));
    exp_q.push_back(p1(rl(-36)));
    exp_q.push_back(p1(rl(MAXP)));
    push_fm4_cycles();
    check_stream("avg_signed");

    // 5x5 map with i_en gaps; trailing row/column discarded
    for (int i = 0; i < 25; i++) stim[i] = pk(i, -i);
    sel = 2;
    do_reset();
    drive_frame(25, 1'b1);
    exp_q.push_back(p1(rl(6)));
    exp_q.push_back(p1(rl(8)));
    exp_q.push_back(p1(rl(16)));
    exp_q.push_back(p1(rl(18)));
    exp_cyc.push_back(acc_edge[6]);
    exp_cyc.push_back(acc_edge[8]);
    exp_cyc.push_back(acc_edge[16]);
    exp_cyc.push_back(acc_edge[18]);
    check_stream("fm5_gap");
    check_done("fm5_gap", acc_edge[24]);

    // reset mid-frame, then samples without i_go, then a clean frame
    sel = 0;
    do_reset();
    start_frame();
    for (int i = 0; i < 9; i++) send(i, 1'b0);
    check_eq("mid_busy", 96'(m_busy), 96'(1));
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_en", 96'(m_en), 96'(0));
    check_eq("abort_data", m_data, 96'(0));
    check_eq("abort_busy", 96'(m_busy), 96'(0));
    check_eq("abort_done", 96'(m_done), 96'(0));
    rst = 1'b0;
    clear_caps();
    for (int i = 9; i < 16; i++) send(i, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("abort_no_en", 96'(got_q.size()), 96'(0));
    check_eq("abort_no_done", 96'(done_cyc.size()), 96'(0));
    drive_frame(16, 1'b0);
    exp_q.push_back(pk(rl(5), rl(0)));
    exp_q.push_back(pk(rl(7), rl(-2)));
    exp_q.push_back(pk(rl(13), rl(-8)));
    exp_q.push_back(pk(rl(15), rl(-10)));
    push_fm4_cycles();
    check_stream("after_abort");
    check_done("after_abort", acc_edge[15]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
